// File: rtl/tdes_block_sequencer.sv
// Multi-block job sequencer between the bus slave and the triple-DES core.
// CBC chaining (chain register, iv, iv_load, cbc_mode) is compiled in by `define TDES_SEQ_CBC_EN.
module tdes_block_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BLK_W = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  input  logic             encr_decr,
  input  logic             cbc_mode,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  output logic             core_start,
  output logic             core_encr_decr,
  output logic [BLK_W-1:0] core_data,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_result,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_issue;
  logic             w_in_pop;
  logic             w_out_push;
  logic             w_iv_ld;
  logic             w_iv_req;

  logic [BLK_W-1:0] r_in_mem [DEPTH];
  logic [AW-1:0]    r_in_wr;
  logic [AW-1:0]    r_in_rd;
  logic [CNT_W-1:0] r_in_cnt;
  logic             w_in_push;
  logic             w_in_pop_g;
  logic [BLK_W-1:0] w_in_head;

  logic [BLK_W-1:0] r_out_mem [DEPTH];
  logic [AW-1:0]    r_out_wr;
  logic [AW-1:0]    r_out_rd;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] w_out_cnt_nxt;
  logic [AW-1:0]    w_out_rd_nxt;
  logic [BLK_W-1:0] w_out_head_nxt;
  logic [BLK_W-1:0] r_out_data;
  logic             w_out_pop;

  logic             r_core_start;
  logic [BLK_W-1:0] r_core_data;
  logic             r_blk_ed;
  logic [BLK_W-1:0] w_core_data_nxt;
  logic [BLK_W-1:0] w_res;

  assign in_ready       = (r_in_cnt != CNT_W'(DEPTH));
  assign out_valid      = (r_out_cnt != '0);
  assign out_data       = r_out_data;
  assign in_count       = r_in_cnt;
  assign out_count      = r_out_cnt;
  assign busy           = (r_state != S_IDLE);
  assign core_start     = r_core_start;
  assign core_data      = r_core_data;
  assign core_encr_decr = r_blk_ed;

  // State register
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Output space is reserved at issue, so the push on core_done never overflows
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_in_pop    = 1'b0;
    w_out_push  = 1'b0;
    w_iv_ld     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_iv_req) begin
          w_iv_ld = 1'b1;
        end else if ((r_in_cnt != '0) && (r_out_cnt != CNT_W'(DEPTH))) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_in_pop    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          w_out_push  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input FIFO
  assign w_in_push  = in_valid && in_ready;
  assign w_in_pop_g = w_in_pop && (r_in_cnt != '0);
  assign w_in_head  = r_in_mem[r_in_rd];

  always_ff @(posedge HCLK) begin
    if (w_in_push) r_in_mem[r_in_wr] <= in_data;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push)  r_in_wr <= r_in_wr + AW'(1);
      if (w_in_pop_g) r_in_rd <= r_in_rd + AW'(1);
      if (w_in_push && !w_in_pop_g)      r_in_cnt <= r_in_cnt + CNT_W'(1);
      else if (!w_in_push && w_in_pop_g) r_in_cnt <= r_in_cnt - CNT_W'(1);
    end
  end

  // Output FIFO with registered first-word fall-through head
  assign w_out_pop    = out_valid && out_ready;
  assign w_out_rd_nxt = w_out_pop ? (r_out_rd + AW'(1)) : r_out_rd;
  assign w_out_head_nxt = (w_out_push && (w_out_rd_nxt == r_out_wr)) ? w_res
                                                                     : r_out_mem[w_out_rd_nxt];

  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (w_out_push && !w_out_pop)      w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
    else if (!w_out_push && w_out_pop) w_out_cnt_nxt = r_out_cnt - CNT_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (w_out_push) r_out_mem[r_out_wr] <= w_res;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_out_wr   <= '0;
      r_out_rd   <= '0;
      r_out_cnt  <= '0;
      r_out_data <= '0;
    end else begin
      if (w_out_push) r_out_wr <= r_out_wr + AW'(1);
      r_out_rd  <= w_out_rd_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      if (w_out_cnt_nxt != '0) r_out_data <= w_out_head_nxt;
    end
  end

  // Core request registers, loaded on the IDLE->ISSUE decision and held through WAIT
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_core_start <= 1'b0;
      r_core_data  <= '0;
      r_blk_ed     <= 1'b0;
    end else begin
      r_core_start <= w_issue;
      if (w_issue) begin
        r_blk_ed    <= encr_decr;
        r_core_data <= w_core_data_nxt;
      end
    end
  end

`ifdef TDES_SEQ_CBC_EN
  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_hold_in;
  logic             r_blk_cbc;

  assign w_iv_req        = iv_load;
  assign w_core_data_nxt = (cbc_mode && encr_decr) ? (w_in_head ^ r_chain) : w_in_head;
  assign w_res           = (r_blk_cbc && !r_blk_ed) ? (core_result ^ r_chain) : core_result;

  // Chain only moves on an IDLE iv_load or when a CBC block completes
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_chain   <= '0;
      r_hold_in <= '0;
      r_blk_cbc <= 1'b0;
    end else begin
      if (w_issue) begin
        r_hold_in <= w_in_head;
        r_blk_cbc <= cbc_mode;
      end
      if (w_iv_ld)                      r_chain <= iv;
      else if (w_out_push && r_blk_cbc) r_chain <= r_blk_ed ? core_result : r_hold_in;
    end
  end
`else
  logic w_unused;

  assign w_iv_req        = 1'b0;
  assign w_core_data_nxt = w_in_head;
  assign w_res           = core_result;
  assign w_unused        = ^{cbc_mode, iv_load, iv, w_iv_ld};
`endif

endmodule
